// File: rtl/snake_pkg.sv
// Shared types, scan-code constants and decode helpers for the Snake keyboard controller.
package snake_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } key_state_e;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } dir_req_t;

    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodeBatOk = 8'hAA;
    localparam logic [7:0] CodeAck   = 8'hFA;
    localparam logic [7:0] CodeW     = 8'h1D;
    localparam logic [7:0] CodeS     = 8'h1B;
    localparam logic [7:0] CodeA     = 8'h1C;
    localparam logic [7:0] CodeD     = 8'h23;
    localparam logic [7:0] CodeSpace = 8'h29;
    localparam logic [7:0] CodeEnter = 8'h5A;
    localparam logic [7:0] CodeUp    = 8'h75;
    localparam logic [7:0] CodeDown  = 8'h72;
    localparam logic [7:0] CodeLeft  = 8'h6B;
    localparam logic [7:0] CodeRight = 8'h74;

    function automatic dir_req_t decode_plain(input logic [7:0] code);
        dir_req_t req;
        req = '{valid: 1'b1, dir: DirUp};
        case (code)
            CodeW:   req.dir = DirUp;
            CodeS:   req.dir = DirDown;
            CodeA:   req.dir = DirLeft;
            CodeD:   req.dir = DirRight;
            default: req.valid = 1'b0;
        endcase
        return req;
    endfunction

    function automatic dir_req_t decode_ext(input logic [7:0] code);
        dir_req_t req;
        req = '{valid: 1'b1, dir: DirUp};
        case (code)
            CodeUp:    req.dir = DirUp;
            CodeDown:  req.dir = DirDown;
            CodeLeft:  req.dir = DirLeft;
            CodeRight: req.dir = DirRight;
            default:   req.valid = 1'b0;
        endcase
        return req;
    endfunction

    // UP/DOWN and LEFT/RIGHT differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular buffer of directions; push and pop may coincide, flush has priority.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  dir_t                   din,
    output dir_t                   head,
    output dir_t                   tail,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    dir_t            mem_q [Depth];
    dir_t            mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
    assign tail  = mem_q[wr_ptr_q - PtrW'(1)];

    // A push into a full buffer is accepted only when a slot frees on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= DirRight;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/snake_key_ctrl.sv
// PS/2 scan-code decoder producing a queued, reversal-filtered snake direction plus
// pause/restart controls for the game FSM.
module snake_key_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned QDEPTH      = 2
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [7:0]              code,
    input  logic                    code_valid,
    input  logic                    tick,
    output logic [1:0]              dir,
    output logic                    paused,
    output logic                    restart,
    output logic [$clog2(QDEPTH):0] q_count
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYC);

    key_state_e      state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    dir_t            dir_q, dir_d;
    logic            paused_q, paused_d;
    logic            restart_q, restart_d;

    dir_req_t dec;
    logic     toggle_pause;
    logic     fire_restart;
    logic     timed_out;

    dir_t                    fifo_head, fifo_tail, ref_dir;
    logic [$clog2(QDEPTH):0] fifo_count;
    logic                    fifo_full, fifo_empty;
    logic                    push_ok, pop_ok;

    assign timed_out = (wait_cnt_q >= TimeoutVal);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (code_valid) begin
            wait_cnt_d = '0;
        end else if (!timed_out) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
    end

    // A byte arriving in the timeout cycle is still handled in the current state.
    always_comb begin
        state_d      = state_q;
        dec          = '{valid: 1'b0, dir: DirUp};
        toggle_pause = 1'b0;
        fire_restart = 1'b0;
        if (code_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (code == CodeExt) begin
                        state_d = StExt;
                    end else if (code == CodeBrk) begin
                        state_d = StBrk;
                    end else if (code == CodeSpace) begin
                        toggle_pause = 1'b1;
                    end else if (code == CodeEnter) begin
                        fire_restart = 1'b1;
                    end else if (code != CodeBatOk && code != CodeAck) begin
                        dec = decode_plain(code);
                    end
                end
                StExt: begin
                    if (code == CodeBrk) begin
                        state_d = StExtBrk;
                    end else begin
                        dec     = decode_ext(code);
                        state_d = StIdle;
                    end
                end
                StBrk, StExtBrk: begin
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && timed_out) begin
            state_d = StIdle;
        end
    end

    // Filter against the pre-edge tail, or the applied direction when nothing is queued.
    always_comb begin
        ref_dir = fifo_empty ? dir_q : fifo_tail;
        pop_ok  = tick && !paused_q && !fifo_empty && !fire_restart;
        push_ok = dec.valid && !fire_restart
                  && (dec.dir != ref_dir) && (dec.dir != opposite(ref_dir));
    end

    always_comb begin
        dir_d     = dir_q;
        paused_d  = paused_q;
        restart_d = fire_restart;
        if (fire_restart) begin
            dir_d    = DirRight;
            paused_d = 1'b0;
        end else begin
            if (pop_ok) begin
                dir_d = fifo_head;
            end
            if (toggle_pause) begin
                paused_d = ~paused_q;
            end
        end
    end

    dir_fifo #(
        .Depth (QDEPTH)
    ) u_dir_fifo (
        .CLK    (CLK),
        .RESETN (RESETN),
        .push   (push_ok),
        .pop    (pop_ok),
        .flush  (fire_restart),
        .din    (dec.dir),
        .head   (fifo_head),
        .tail   (fifo_tail),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            dir_q      <= DirRight;
            paused_q   <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            dir_q      <= dir_d;
            paused_q   <= paused_d;
            restart_q  <= restart_d;
        end
    end

    assign dir     = dir_q;
    assign paused  = paused_q;
    assign restart = restart_q;
    assign q_count = fifo_count;

endmodule

// File: tb/tb_snake_key_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus random byte/tick
// traffic compared every cycle against a behavioural model.
module tb_snake_key_ctrl;

    localparam int TO = 20;
    localparam int QD = 2;

    logic              CLK = 1'b0;
    logic              RESETN = 1'b0;
    logic [7:0]        code = 8'h00;
    logic              code_valid = 1'b0;
    logic              tick = 1'b0;
    logic [1:0]        dir;
    logic              paused;
    logic              restart;
    logic [$clog2(QD):0] q_count;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model state: pending prefixes, idle-cycle count, applied direction and the queue.
    bit m_ext, m_brk;
    int m_wait;
    int m_dir, m_paused, m_restart;
    int m_q[$];

    snake_key_ctrl #(
        .TIMEOUT_CYC (TO),
        .QDEPTH      (QD)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .code       (code),
        .code_valid (code_valid),
        .tick       (tick),
        .dir        (dir),
        .paused     (paused),
        .restart    (restart),
        .q_count    (q_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int plain_dir(input logic [7:0] c);
        case (c)
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int ext_dir(input logic [7:0] c);
        case (c)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_wait = 0;
        m_dir = 3; m_paused = 0; m_restart = 0;
        m_q.delete();
    endfunction

    function automatic void model_edge(input logic [7:0] c, input bit v, input bit t);
        int d = -1;
        int rf;
        bit pz = 0, rs = 0, pop, push;
        pop = t && (m_paused == 0) && (m_q.size() > 0);
        if (v) begin
            if (m_brk) begin
                m_ext = 0; m_brk = 0;
            end else if (m_ext) begin
                if (c == 8'hF0) m_brk = 1;
                else begin d = ext_dir(c); m_ext = 0; end
            end else if (c == 8'hE0) m_ext = 1;
            else if (c == 8'hF0) m_brk = 1;
            else if (c == 8'h29) pz = 1;
            else if (c == 8'h5A) rs = 1;
            else if (c != 8'hAA && c != 8'hFA) d = plain_dir(c);
            m_wait = 0;
        end else begin
            if ((m_ext || m_brk) && m_wait >= TO) begin m_ext = 0; m_brk = 0; end
            if (m_wait < TO) m_wait++;
        end
        m_restart = rs;
        if (rs) begin
            m_q.delete(); m_dir = 3; m_paused = 0;
        end else begin
            rf = (m_q.size() > 0) ? m_q[$] : m_dir;
            push = (d >= 0) && (d != rf) && (d != (rf ^ 1)) && (m_q.size() < QD || pop);
            if (pop) m_dir = m_q.pop_front();
            if (push) m_q.push_back(d);
            if (pz) m_paused = (m_paused == 0) ? 1 : 0;
        end
    endfunction

    always @(negedge CLK) begin
        if (chk_en && RESETN) begin
            chk("cyc_dir", dir, m_dir);
            chk("cyc_paused", paused, m_paused);
            chk("cyc_restart", restart, m_restart);
            chk("cyc_q_count", q_count, m_q.size());
        end
    end

    task automatic step(input logic [7:0] c, input bit v, input bit t);
        code = c; code_valid = v; tick = t;
        @(posedge CLK);
        model_edge(c, v, t);
        #1;
        code_valid = 1'b0; tick = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        step(c, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        model_reset();
        #1;
        chk("rst_dir", dir, 3);
        chk("rst_paused", paused, 0);
        chk("rst_restart", restart, 0);
        chk("rst_q_count", q_count, 0);
        @(negedge CLK);
        RESETN = 1'b1;
        step(8'h00, 1'b0, 1'b0);
    endtask

    logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                              8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'h00};

    initial begin
        model_reset();
        #12;
        do_reset();
        chk_en = 1'b1;

        // Extended arrow then tick.
        send(8'hE0); send(8'h75);
        chk("ext_up_q", q_count, 1);
        step(8'h00, 1'b0, 1'b1);
        chk("ext_up_dir", dir, 0);
        chk("ext_up_q0", q_count, 0);

        // Reversal rejected, then two queued entries.
        do_reset();
        send(8'h1C);
        chk("reversal_q", q_count, 0);
        send(8'h1D); send(8'h1C);
        chk("two_q", q_count, 2);
        step(8'h00, 1'b0, 1'b1);
        chk("pop1_dir", dir, 0);
        step(8'h00, 1'b0, 1'b1);
        chk("pop2_dir", dir, 2);
        chk("pop2_q", q_count, 0);

        // Typematic repeats and a break code.
        for (int i = 0; i < 5; i++) send(8'h1D);
        chk("typematic_q", q_count, 1);
        send(8'hF0); send(8'h1D);
        chk("break_q", q_count, 1);
        step(8'h00, 1'b0, 1'b1);
        chk("typematic_dir", dir, 0);

        // Full queue and push coinciding with a pop.
        do_reset();
        send(8'h1D); send(8'h23); send(8'h1B);
        chk("full_q", q_count, 2);
        step(8'h1B, 1'b1, 1'b1);
        chk("full_pushpop_q", q_count, 2);
        chk("full_pushpop_dir", dir, 0);

        // Pause blocks ticks; Enter restarts.
        send(8'h29);
        chk("pause_on", paused, 1);
        step(8'h00, 1'b0, 1'b1);
        chk("paused_dir", dir, 0);
        chk("paused_q", q_count, 2);
        send(8'h5A);
        chk("restart_pulse", restart, 1);
        chk("restart_paused", paused, 0);
        chk("restart_dir", dir, 3);
        chk("restart_q", q_count, 0);
        idle(1);
        chk("restart_low", restart, 0);

        // Prefix timeout vs. a byte arriving in time.
        send(8'hE0); idle(TO + 2); send(8'h75);
        chk("timeout_q", q_count, 0);
        send(8'hE0); idle(TO - 5); send(8'h75);
        chk("no_timeout_q", q_count, 1);

        // Reset in the middle of an extended sequence.
        send(8'hE0);
        do_reset();
        send(8'h75);
        chk("midreset_q", q_count, 0);
        chk("midreset_dir", dir, 3);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                idle(TO + $urandom_range(0, 3) - 2);
            end else begin
                step(pool[$urandom_range(0, 15)], $urandom_range(0, 99) < 50,
                     $urandom_range(0, 99) < 30);
            end
        end

        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
